// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and FSM state encodings shared by the ALU pipe
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - sequential shift-add multiplier, one partial product per cycle
module alu_mul_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int SW = $clog2(N);

  logic [2*N-1:0] mcand_q, mcand_d, acc_q, acc_d, addend;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;

  // product already includes the current step so the owner can load it on done
  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    product  = acc_q + addend;
    done     = busy_q && (cnt_q == SW'(N-1));
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = {{N{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + SW'(1);
      busy_d   = !done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - valid/ready ALU with registered result, flags and multi-cycle multiply
module alu_pipe
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   opcode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v
);
  localparam int SW = $clog2(N);

  state_t         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   result_q, result_d;
  logic           flag_z_q, flag_z_d, flag_c_q, flag_c_d, flag_v_q, flag_v_d;
  logic           run_q, run_d;
  logic           accept, mul_start, mul_done;
  logic [2*N-1:0] mul_product;
  logic [N:0]     add_full, sub_full;
  logic [N-1:0]   alu_r;
  logic           alu_c, alu_v;

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;

  // run_q keeps in_ready low until the first edge after reset is released
  always_comb begin
    run_d     = 1'b1;
    in_ready  = run_q && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    accept    = in_valid && in_ready;
    mul_start = accept && (opcode == OP_MUL);
  end

  alu_mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} - {1'b0, b};
    alu_r    = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_r = add_full[N-1:0];
        alu_c = add_full[N];
        alu_v = (a[N-1] == b[N-1]) && (alu_r[N-1] != a[N-1]);
      end
      OP_SUB: begin
        alu_r = sub_full[N-1:0];
        alu_c = sub_full[N];
        alu_v = (a[N-1] != b[N-1]) && (alu_r[N-1] != a[N-1]);
      end
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_XOR:  alu_r = a ^ b;
      OP_SLL:  alu_r = a << b[SW-1:0];
      OP_SRL:  alu_r = a >> b[SW-1:0];
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    flag_v_d    = flag_v_q;
    case (state_q)
      ST_IDLE: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
          if (opcode == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_r;
            flag_z_d    = (alu_r == '0);
            flag_c_d    = alu_c;
            flag_v_d    = alu_v;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          out_valid_d = 1'b1;
          result_d    = mul_product[N-1:0];
          flag_z_d    = (mul_product[N-1:0] == '0);
          flag_c_d    = |mul_product[2*N-1:N];
          flag_v_d    = 1'b0;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      flag_v_q    <= flag_v_d;
      run_q       <= run_d;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe against an arithmetic reference model
module tb_alu_pipe;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   opcode = 3'd0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] result;
  logic         flag_z, flag_c, flag_v;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [N-1:0] r;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  exp_t exp_q[$];

  wire [N+3:0] obs = {out_valid, result, flag_z, flag_c, flag_v};

  alu_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Reference: integer arithmetic on the values, wrapped to N bits at the end
  function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    int ux, uy, sx, sy, full, lim, s;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    lim = 1 << N;
    full = 0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      3'd0: begin full = ux + uy; s = sx + sy; e.c = (full >= lim); e.v = (s > lim/2 - 1) || (s < -lim/2); end
      3'd1: begin full = ux - uy; s = sx - sy; e.c = (ux < uy); e.v = (s > lim/2 - 1) || (s < -lim/2); end
      3'd2: full = ux & uy;
      3'd3: full = ux | uy;
      3'd4: full = ux ^ uy;
      3'd5: full = ux << (uy % N);
      3'd6: full = ux >> (uy % N);
      default: begin full = ux * uy; e.c = (full >= lim); end
    endcase
    e.r = full[N-1:0];
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
    in_valid = 1'b1;
    opcode = op;
    a = x;
    b = y;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want %h", obs, {(N+4){1'b0}}); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL in_ready_before_edge: got %b want 0", in_ready); end
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL in_ready_after_edge: got %b want 1", in_ready); end
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1;
    issue(3'd0, 8'hFF, 8'h01);
    total++;
    if (obs !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin bad++; $display("FAIL add_ff_01: got %h want %h", obs, {1'b1, 8'h00, 3'b110}); end
    issue(3'd1, 8'h80, 8'h01);
    total++;
    if (obs !== {1'b1, 8'h7F, 1'b0, 1'b0, 1'b1}) begin bad++; $display("FAIL sub_80_01: got %h want %h", obs, {1'b1, 8'h7F, 3'b001}); end
    issue(3'd1, 8'h01, 8'h02);
    total++;
    if (obs !== {1'b1, 8'hFF, 1'b0, 1'b1, 1'b0}) begin bad++; $display("FAIL sub_01_02: got %h want %h", obs, {1'b1, 8'hFF, 3'b010}); end
    tick();
  endtask

  task automatic test_mul();
    int stalls;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mul_ready_idle: got %b want 1", in_ready); end
    issue(3'd7, 8'h0F, 8'h11);
    stalls = 0;
    for (int k = 1; k <= N; k++) begin
      if (in_ready === 1'b0 && out_valid === 1'b0) stalls++;
      tick();
    end
    total++;
    if (stalls != N) begin bad++; $display("FAIL mul_busy_cycles: got %0d want %0d", stalls, N); end
    total++;
    if (obs !== {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0}) begin bad++; $display("FAIL mul_0f_11: got %h want %h", obs, {1'b1, 8'hFF, 3'b000}); end
    tick();
    issue(3'd7, 8'h10, 8'h10);
    for (int k = 1; k <= N; k++) tick();
    total++;
    if (obs !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin bad++; $display("FAIL mul_10_10: got %h want %h", obs, {1'b1, 8'h00, 3'b110}); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(3'd4, 8'hAA, 8'h0F);
    in_valid = 1'b1;
    opcode = 3'd5;
    a = 8'h01;
    b = 8'h0B;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if ({in_ready, obs} !== {1'b0, 1'b1, 8'hA5, 3'b000}) begin
        bad++;
        $display("FAIL backpressure_hold: got %h want %h", {in_ready, obs}, {1'b0, 1'b1, 8'hA5, 3'b000});
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++;
    if (obs !== {1'b1, 8'h08, 3'b000}) begin bad++; $display("FAIL sll_after_drain: got %h want %h", obs, {1'b1, 8'h08, 3'b000}); end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    int ghosts;
    out_ready = 1'b1;
    issue(3'd7, 8'h0F, 8'h11);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, obs} !== '0) begin bad++; $display("FAIL reset_mid_mul: got %h want 0", {in_ready, obs}); end
    tick();
    rst_n = 1'b1;
    tick();
    issue(3'd0, 8'h03, 8'h04);
    total++;
    if (obs !== {1'b1, 8'h07, 3'b000}) begin bad++; $display("FAIL add_after_reset: got %h want %h", obs, {1'b1, 8'h07, 3'b000}); end
    tick();
    ghosts = 0;
    for (int k = 0; k < N + 4; k++) begin
      if (out_valid !== 1'b0) ghosts++;
      tick();
    end
    total++;
    if (ghosts != 0) begin bad++; $display("FAIL discarded_mul_output: got %0d valid cycles want 0", ghosts); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int not_ready;
    logic [2:0] op;
    out_ready = 1'b1;
    not_ready = 0;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 6));
      in_valid = 1'b1;
      opcode = op;
      a = N'($urandom);
      b = N'($urandom);
      e = model(op, a, b);
      #1;
      if (in_ready !== 1'b1) not_ready++;
      tick();
      total++;
      if (obs !== {1'b1, e.r, e.z, e.c, e.v}) begin
        bad++;
        $display("FAIL back_to_back op%0d: got %h want %h", op, obs, {1'b1, e.r, e.z, e.c, e.v});
      end
    end
    in_valid = 1'b0;
    total++;
    if (not_ready != 0) begin bad++; $display("FAIL back_to_back_rate: got %0d stalls want 0", not_ready); end
    tick();
  endtask

  task automatic test_random();
    exp_t e;
    logic stall_prev;
    logic [N+3:0] held;
    stall_prev = 1'b0;
    held = '0;
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      opcode = 3'($urandom_range(0, 7));
      a = N'($urandom);
      b = N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (stall_prev) begin
        total++;
        if (obs !== held) begin bad++; $display("FAIL stall_stable cyc%0d: got %h want %h", i, obs, held); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL random_unexpected cyc%0d: got %h want no output", i, obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== {1'b1, e.r, e.z, e.c, e.v}) begin
            bad++;
            $display("FAIL random_result cyc%0d: got %h want %h", i, obs, {1'b1, e.r, e.z, e.c, e.v});
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(opcode, a, b));
      stall_prev = out_valid && !out_ready;
      held = obs;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3 * N; i++) begin
      #1;
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL drain_unexpected: got %h want no output", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== {1'b1, e.r, e.z, e.c, e.v}) begin
            bad++;
            $display("FAIL drain_result: got %h want %h", obs, {1'b1, e.r, e.z, e.c, e.v});
          end
        end
      end
      tick();
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL drain_lost: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter N, default 8, operand and result width; legal values are powers of two from 4 to 64.
REQ-002 The block SHALL have localparam SW = $clog2(N), the shift-amount width.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: opcode and operands are valid.
REQ-006 Port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 Port opcode, input, 3 bits: operation select.
REQ-008 Port a, input, N bits: first operand.
REQ-009 Port b, input, N bits: second operand.
REQ-010 Port out_valid, output, 1 bit: result and flags are valid.
REQ-011 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 Port result, output, N bits: operation result.
REQ-013 Port flag_z, output, 1 bit: the result is zero.
REQ-014 Port flag_c, output, 1 bit: carry, borrow, or multiply overflow.
REQ-015 Port flag_v, output, 1 bit: signed overflow.

Function
REQ-016 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL; all eight codes are legal.
REQ-017 Arithmetic SHALL be modulo 2^N.
- SLL/SRL shift amount = b[SW-1:0]; upper bits of b ignored; SRL is logical (zero fill).
- MUL result = low N bits of the unsigned product a*b.
REQ-018 A transfer SHALL occur on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-019 An FSM SHALL have states IDLE, MUL, HOLD.
REQ-020 in_ready SHALL be 1 only in IDLE, and only when !out_valid || out_ready (output drains in the same cycle).
REQ-021 IDLE, non-MUL accept: result and flags SHALL be registered, with out_valid=1 the next cycle (latency 1).
- Back-to-back accepts SHALL sustain 1 op/cycle while out_ready=1.
REQ-022 IDLE, MUL accept: operands SHALL be latched, go to MUL, and perform one shift-add step per cycle for N cycles.
- The last step SHALL load result/flags, set out_valid, and go to HOLD.
- Total accept-to-out_valid latency = N+1 cycles.
REQ-023 HOLD SHALL return to IDLE on the cycle out_ready=1.
- out_valid is cleared unless a new op is accepted in that same cycle (allowed per REQ-020 only from IDLE, so HOLD drains first).
REQ-024 While out_valid=1 && out_ready=0, result and flags SHALL hold stable and no new operation SHALL be accepted.
REQ-025 in_valid, opcode, a, and b SHALL be ignored when in_ready=0.
- Operand changes during MUL SHALL NOT affect the product.
REQ-026 flag_z SHALL be (result == 0) for all ops.
REQ-027 flag_c SHALL be set as follows:
- ADD: carry out of bit N-1.
- SUB: borrow, i.e. a < b unsigned.
- MUL: 1 if the upper N product bits are nonzero.
- All other ops: 0.
REQ-028 flag_v SHALL be set as follows:
- ADD: signed overflow, operands same sign and result sign differs.
- SUB: operands differ in sign and result sign differs from a.
- All other ops: 0.
REQ-029 The block SHALL contain no combinational path from in_valid/opcode/a/b to result/flags/out_valid.

Reset
REQ-030 rst_n=0 SHALL force, asynchronously: state=IDLE, out_valid=0, result=0, flag_z=0, flag_c=0, flag_v=0, multiply accumulator and counter=0.
REQ-031 in_ready SHALL be 0 while rst_n=0.
- It is 1 from the first clock edge after deassertion.
REQ-032 Reset mid-MUL or in HOLD SHALL discard the operation with no output transfer.

Structure
REQ-033 Opcode localparams (OP_ADD..OP_MUL) and FSM state encodings SHALL live in shared package alu_pkg.
REQ-034 The shift-add multiplier SHALL be sub-module alu_mul_seq (parameter N; ports clk, rst_n, start, a, b, done, product[2N-1:0]).
- alu_pipe owns the handshake, flags, and output register.

Verification (N=8)
REQ-035 ADD a=0xFF b=0x01, out_ready=1 -> next cycle out_valid=1, result=0x00, z=1, c=1, v=0.
REQ-036 SUB a=0x80 b=0x01 -> result=0x7F, z=0, c=0, v=1; SUB a=0x01 b=0x02 -> result=0xFF, c=1, v=0.
REQ-037 MUL a=0x0F b=0x11 -> in_ready=0 for 8 cycles, out_valid at cycle 9, result=0xFF, c=0; MUL 0x10*0x10 -> result=0x00, z=1, c=1.
REQ-038 Hold out_ready=0, issue XOR 0xAA^0x0F then present SLL 0x01<<0x0B -> result stays 0x A5 with in_ready=0; raise out_ready -> SLL accepted, next result=0x08.
REQ-039 Assert rst_n=0 at cycle 4 of a MUL -> out_valid=0, result=0 immediately; after release a fresh ADD 0x03+0x04 -> result=0x07 at latency 1.
